csel_sub_pipe: RTL and testbench
================================

Name: csel_sub_pipe

Overview:
- Pipelined carry-select subtractor: computes diff = a - b - bin, one BLOCK-bit slice per pipeline stage.
- Each slice precomputes both borrow-in cases and picks one with a mux when the registered borrow from the previous slice arrives.
- Sits beside the combinational carry-select adders as the subtract datapath for higher-clock-rate users.
- Valid/ready handshake on input and output; full-throughput streaming with backpressure.

Parameters:
- WIDTH, 16, operand and result width in bits. Must be a multiple of BLOCK and at least 2*BLOCK.
- BLOCK, 4, slice width in bits; one slice per pipeline stage.
- NUM_STAGES, WIDTH/BLOCK, derived; this is the latency in cycles. Not for override.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands this cycle.
- a  in  WIDTH  minuend, unsigned or two's complement.
- b  in  WIDTH  subtrahend.
- bin  in  1  borrow in.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- diff  out  WIDTH  (a - b - bin) mod 2^WIDTH.
- bout  out  1  borrow out; 1 iff a < b + bin, unsigned.
- ovf  out  1  signed overflow.
- zero  out  1  diff == 0.

Behaviour:
- Reset: clk and rst are the only clock and reset. rst is asynchronous, active-high.
  - On rst, clear all stage valid bits and all data registers to 0 immediately.
  - While in reset: out_valid=0, diff=0, bout=0, ovf=0, zero=0.
  - in_ready=0 while rst is high; in_ready=1 from the first cycle after release.
- Arithmetic: diff = a + ~b + carry_in, where carry_in = ~bin. bout = ~carry_out of the top slice.
- ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]). Use registered copies of the operand MSBs carried to the last stage.
- zero is computed from the final diff.
- Stage k (k = 0..NUM_STAGES-1) combinationally computes slice k:
  - two speculative BLOCK-bit sums, with carry-in 0 and 1;
  - a mux selects one using the carry held in stage k's register (stage 0 uses ~bin from the ports).
- Stage k+1 registers: the produced diff bits, the selected carry, the unconsumed operand bits, and a valid bit.
- Stage 0 is combinational from the ports into the first register.
- Advance: global enable adv = !out_valid || out_ready; in_ready = adv.
  - When adv=1, every stage register loads from its predecessor. Stage-1 valid loads in_valid.
  - When adv=0, every register holds.
- Latency: operands accepted on edge t (in_valid && in_ready) appear with out_valid=1 after edge t+NUM_STAGES-1. That is NUM_STAGES cycles.
- Throughput: one operation per cycle when out_ready is held high.
- Backpressure: out_valid=1 with out_ready=0 freezes the whole pipeline.
  - diff, bout, ovf and zero stay stable.
  - in_ready=0 for that cycle; no data is lost or duplicated.
- Bubbles: the valid bit of an empty stage is 0. Data registers of empty stages may load anything and are don't-care.
  - out_valid = valid bit of the last stage.
- Simultaneous accept and emit in one cycle is legal and normal.
- Reset mid-operation discards all in-flight operations. No result from before reset ever appears after release.
- Outputs are registered; there is no combinational path from a, b or bin to the outputs.
- in_ready depends combinationally on out_ready only.

Decomposition:
- Shared package/header (adder_pkg): default WIDTH and BLOCK constants, plus a compile-time check that WIDTH % BLOCK == 0 and WIDTH >= 2*BLOCK.
- One sub-module, sub_csel_slice: BLOCK-bit inputs a, ~b and carry-in; two speculative ripple sums plus the select mux; outputs BLOCK-bit sum and carry-out.
  - Instantiate once per stage via generate.
  - It reuses the existing full_adder cell.

Test Plan:
- a=0x1234, b=0x0234, bin=0, out_ready=1 -> 4 cycles later diff=0x1000, bout=0, ovf=0, zero=0.
- a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0. Then a=0x8000, b=0x0001 -> diff=0x7FFF, bout=0, ovf=1.
- a=0x0005, b=0x0005, bin=1 -> diff=0xFFFF, bout=1. Same operands with bin=0 -> diff=0x0000, zero=1, bout=0.
- Stream 8 back-to-back ops; drop out_ready for 3 cycles mid-stream:
  - in_ready=0 and outputs stable during the stall;
  - all 8 results emerge in order, exactly once;
  - throughput returns to 1/cycle when out_ready rises.
- Issue 3 ops, assert rst asynchronously between edges -> out_valid drops immediately. After release no stale result appears, and the first new op has 4-cycle latency.
- Random a, b, bin (10k vectors, random out_ready) vs reference model {bout, diff} = {1'b0, a} - b - bin, plus the ovf formula -> zero mismatches.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants for the carry-select add/subtract datapaths, plus the
// geometry check every pipelined user applies to its WIDTH/BLOCK pair.
package adder_pkg;

  localparam int ADDER_WIDTH = 16;
  localparam int ADDER_BLOCK = 4;

  function automatic bit cfg_ok(input int width, input int block);
    return (block > 32'sd0) && ((width % block) == 32'sd0) && (width >= (block * 32'sd2));
  endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell shared by the ripple chains of the carry-select slices.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/sub_csel_slice.sv
// One carry-select slice: two speculative ripple sums of a + nb (carry-in 0 and 1),
// resolved by a mux once the real carry-in is known.
module sub_csel_slice
  import adder_pkg::*;
#(
  parameter int BLOCK = ADDER_BLOCK
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] nb,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout
);

  logic [BLOCK:0]   c0_s;
  logic [BLOCK:0]   c1_s;
  logic [BLOCK-1:0] s0_s;
  logic [BLOCK-1:0] s1_s;

  assign c0_s[0] = 1'b0;
  assign c1_s[0] = 1'b1;

  for (genvar i = 0; i < BLOCK; i++) begin : g_bit
    full_adder u_fa0 (.a(a[i]), .b(nb[i]), .ci(c0_s[i]), .s(s0_s[i]), .co(c0_s[i+1]));
    full_adder u_fa1 (.a(a[i]), .b(nb[i]), .ci(c1_s[i]), .s(s1_s[i]), .co(c1_s[i+1]));
  end

  always_comb begin
    if (cin) begin
      sum  = s1_s;
      cout = c1_s[BLOCK];
    end else begin
      sum  = s0_s;
      cout = c0_s[BLOCK];
    end
  end

endmodule

// File: rtl/csel_sub_pipe.sv
// Pipelined carry-select subtractor: diff = a - b - bin, one BLOCK-bit slice per stage,
// valid/ready on both sides with a single global advance enable.
module csel_sub_pipe
  import adder_pkg::*;
#(
  parameter  int WIDTH      = ADDER_WIDTH,
  parameter  int BLOCK      = ADDER_BLOCK,
  localparam int NUM_STAGES = WIDTH / BLOCK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  if (!cfg_ok(WIDTH, BLOCK)) begin : g_cfg_err
    $error("csel_sub_pipe: WIDTH must be a multiple of BLOCK and at least 2*BLOCK");
  end

  logic adv;

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv & ~rst;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    localparam int OPW = WIDTH - k * BLOCK;  // operand bits not yet consumed
    localparam int DW  = (k + 1) * BLOCK;    // result bits known after this slice

    logic [OPW-1:0]   opa_s;
    logic [OPW-1:0]   opnb_s;
    logic             cin_s;
    logic             vin_s;
    logic [BLOCK-1:0] sum_s;
    logic             cout_s;
    logic [DW-1:0]    dnew_s;
    logic [DW-1:0]    dacc_d;
    logic [DW-1:0]    dacc_q;
    logic             valid_d;
    logic             valid_q;

    if (k == 0) begin : g_first
      always_comb begin
        opa_s  = a;
        opnb_s = ~b;
        cin_s  = ~bin;
        vin_s  = in_valid;
        dnew_s = sum_s;
      end
    end else begin : g_chain
      always_comb begin
        opa_s  = g_stage[k-1].g_fwd.rema_q;
        opnb_s = g_stage[k-1].g_fwd.remnb_q;
        cin_s  = g_stage[k-1].g_fwd.carry_q;
        vin_s  = g_stage[k-1].valid_q;
        dnew_s = {sum_s, g_stage[k-1].dacc_q};
      end
    end

    sub_csel_slice #(.BLOCK(BLOCK)) u_slice (
      .a    (opa_s[BLOCK-1:0]),
      .nb   (opnb_s[BLOCK-1:0]),
      .cin  (cin_s),
      .sum  (sum_s),
      .cout (cout_s)
    );

    always_comb begin
      if (adv) begin
        valid_d = vin_s;
        dacc_d  = dnew_s;
      end else begin
        valid_d = valid_q;
        dacc_d  = dacc_q;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        dacc_q  <= {DW{1'b0}};
      end else begin
        valid_q <= valid_d;
        dacc_q  <= dacc_d;
      end
    end

    if (k < NUM_STAGES - 1) begin : g_fwd
      localparam int RW = OPW - BLOCK;

      logic [RW-1:0] rema_d;
      logic [RW-1:0] rema_q;
      logic [RW-1:0] remnb_d;
      logic [RW-1:0] remnb_q;
      logic          carry_d;
      logic          carry_q;

      always_comb begin
        if (adv) begin
          rema_d  = opa_s[OPW-1:BLOCK];
          remnb_d = opnb_s[OPW-1:BLOCK];
          carry_d = cout_s;
        end else begin
          rema_d  = rema_q;
          remnb_d = remnb_q;
          carry_d = carry_q;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rema_q  <= {RW{1'b0}};
          remnb_q <= {RW{1'b0}};
          carry_q <= 1'b0;
        end else begin
          rema_q  <= rema_d;
          remnb_q <= remnb_d;
          carry_q <= carry_d;
        end
      end
    end else begin : g_last
      logic bout_d;
      logic bout_q;
      logic ovf_d;
      logic ovf_q;
      logic zero_d;
      logic zero_q;

      // Operand MSBs here are the registered copies that rode down the pipe.
      always_comb begin
        if (adv) begin
          bout_d = ~cout_s;
          ovf_d  = (opa_s[BLOCK-1] != ~opnb_s[BLOCK-1]) && (sum_s[BLOCK-1] != opa_s[BLOCK-1]);
          zero_d = (dnew_s == {DW{1'b0}});
        end else begin
          bout_d = bout_q;
          ovf_d  = ovf_q;
          zero_d = zero_q;
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          bout_q <= 1'b0;
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else begin
          bout_q <= bout_d;
          ovf_q  <= ovf_d;
          zero_q <= zero_d;
        end
      end
    end
  end

  assign out_valid = g_stage[NUM_STAGES-1].valid_q;
  assign diff      = g_stage[NUM_STAGES-1].dacc_q;
  assign bout      = g_stage[NUM_STAGES-1].g_last.bout_q;
  assign ovf       = g_stage[NUM_STAGES-1].g_last.ovf_q;
  assign zero      = g_stage[NUM_STAGES-1].g_last.zero_q;

endmodule

// File: tb/tb_csel_sub_pipe.sv
// Self-checking bench for csel_sub_pipe: directed vector table, stall and reset
// sequences, then randomized traffic against an arithmetic reference model.
module tb_csel_sub_pipe;

  localparam int WIDTH = 16;
  localparam int BLOCK = 4;
  localparam int NS    = WIDTH / BLOCK;

  typedef struct packed {
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
    logic        zero;
  } res_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    res_t        exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] diff;
  logic        bout;
  logic        ovf;
  logic        zero;

  vec_t vecs[10];
  res_t sb[$];
  res_t held;
  int   checks = 0;
  int   failures = 0;
  int   n_acc;
  int   n_emit;
  int   cyc;
  int   first_emit;
  int   last_emit;
  int   guard;

  csel_sub_pipe #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  // Reference: plain integer subtraction; overflow means the signed result leaves 16-bit range.
  function automatic res_t model(input logic [15:0] ma, input logic [15:0] mb, input logic mbin);
    res_t        r;
    logic [16:0] wide;
    int          sd;
    wide   = {1'b0, ma} - {1'b0, mb} - {16'd0, mbin};
    sd     = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
    r.diff = wide[15:0];
    r.bout = wide[16];
    r.ovf  = (sd > 32767) || (sd < -32768);
    r.zero = (wide[15:0] == 16'd0);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic res_t cur_out();
    res_t r;
    r.diff = diff;
    r.bout = bout;
    r.ovf  = ovf;
    r.zero = zero;
    return r;
  endfunction

  // One cycle of streaming: inputs already set at this negedge; scoreboard both handshakes.
  task automatic tick();
    res_t e;
    #1;
    if (in_valid && in_ready) begin
      sb.push_back(model(a, b, bin));
      n_acc++;
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL stream_extra actual=%0h required=none", cur_out());
      end else begin
        e = sb.pop_front();
        chk("stream_result", 32'(cur_out()), 32'(e));
      end
      n_emit++;
      last_emit = cyc;
      if (first_emit < 0) first_emit = cyc;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_vec(input string name, input vec_t v);
    int lat;
    a = v.a; b = v.b; bin = v.bin; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_lat"},  lat,    NS);
    chk({name, "_diff"}, diff,   v.exp.diff);
    chk({name, "_bout"}, bout,   v.exp.bout);
    chk({name, "_ovf"},  ovf,    v.exp.ovf);
    chk({name, "_zero"}, zero,   v.exp.zero);
    @(negedge clk);
    chk({name, "_once"}, out_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 16'd0; b = 16'd0; bin = 1'b0;
    vecs[0] = '{16'h1234, 16'h0234, 1'b0, '{16'h1000, 1'b0, 1'b0, 1'b0}};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, '{16'hFFFF, 1'b1, 1'b0, 1'b0}};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, '{16'h7FFF, 1'b0, 1'b1, 1'b0}};
    vecs[3] = '{16'h0005, 16'h0005, 1'b1, '{16'hFFFF, 1'b1, 1'b0, 1'b0}};
    vecs[4] = '{16'h0005, 16'h0005, 1'b0, '{16'h0000, 1'b0, 1'b0, 1'b1}};
    vecs[5] = '{16'h7FFF, 16'hFFFF, 1'b0, '{16'h8000, 1'b1, 1'b1, 1'b0}};
    vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b1, '{16'hFFFF, 1'b1, 1'b0, 1'b0}};
    vecs[7] = '{16'h0000, 16'h0000, 1'b1, '{16'hFFFF, 1'b1, 1'b0, 1'b0}};
    vecs[8] = '{16'h8000, 16'h7FFF, 1'b0, '{16'h0001, 1'b0, 1'b1, 1'b0}};
    vecs[9] = '{16'hABCD, 16'h1234, 1'b0, '{16'h9999, 1'b0, 1'b0, 1'b0}};

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready",  in_ready,  1'b0);
    chk("rst_outputs",   32'(cur_out()), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1'b1);
    @(negedge clk);

    // Directed vectors, one at a time, latency checked
    for (int i = 0; i < 10; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Eight back-to-back ops with a 3-cycle consumer stall
    sb.delete(); n_acc = 0; n_emit = 0; cyc = 0; first_emit = -1; last_emit = -1;
    for (int c = 0; c < 60 && n_emit < 8; c++) begin
      in_valid  = (n_acc < 8);
      a         = 16'($urandom);
      b         = 16'($urandom);
      bin       = 1'($urandom);
      out_ready = !(c >= 6 && c <= 8);
      if (c >= 6 && c <= 8) begin
        #1;
        chk("stall_in_ready",  in_ready,  1'b0);
        chk("stall_out_valid", out_valid, 1'b1);
        if (c == 6) held = cur_out();
        else chk("stall_hold", 32'(cur_out()), 32'(held));
      end
      tick();
    end
    in_valid = 1'b0;
    chk("stall_emitted",  n_emit, 8);
    chk("stall_accepted", n_acc,  8);
    chk("stall_span",     last_emit - first_emit, 10);
    chk("stall_sb_empty", sb.size(), 0);

    // Reset with operations in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
      tick();
    end
    in_valid = 1'b0;
    guard = 0;
    while (!out_valid && guard < 10) begin
      tick();
      guard++;
    end
    chk("prerst_out_valid", out_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready",  in_ready,  1'b0);
    chk("midrst_outputs",   32'(cur_out()), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("no_stale", out_valid, 1'b0);
      @(negedge clk);
    end
    run_vec("postrst", vecs[0]);

    // Randomized traffic with random backpressure
    sb.delete(); n_acc = 0; n_emit = 0; cyc = 0; first_emit = -1; last_emit = -1;
    guard = 0;
    while (n_acc < 10000 && guard < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a         = 16'($urandom);
      b         = 16'($urandom);
      bin       = 1'($urandom);
      tick();
      guard++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      tick();
      guard++;
    end
    chk("rnd_accepted", n_acc, 10000);
    chk("rnd_drained",  sb.size(), 0);
    chk("rnd_emitted",  n_emit, n_acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
